// File: rtl/lorenz_euler_core.sv
// Fixed-point Lorenz-attractor integrator using forward Euler steps.
// A single registered multiplier is time-shared over four cycles per step
// (M0..M3), the state is updated in UPD, and each step result is offered
// on a valid/ready stream in OUT.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 run request, sampled only while idle
//   x0, y0, z0            initial state (signed fixed point, FRAC_W fraction bits)
//   num_steps             number of Euler steps in the run
//   x_out, y_out, z_out   current state
//   out_valid, out_ready  per-step result handshake
//   busy                  run in progress
//   done                  one-cycle pulse after the last result is accepted
module lorenz_euler_core #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       FRAC_W   = 16,
    parameter logic [DATA_W-1:0] SIGMA    = 32'h000A0000,
    parameter logic [DATA_W-1:0] RHO      = 32'h001C0000,
    parameter logic [DATA_W-1:0] BETA     = 32'h0002AAAB,
    parameter int unsigned       DT_SHIFT = 8,
    parameter int unsigned       STEP_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] y0,
    input  logic [DATA_W-1:0] z0,
    input  logic [STEP_W-1:0] num_steps,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] z_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WIDE_W = 2 * DATA_W;

    typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StUpd, StOut} state_t;

    // Clamp a wide signed value into the DATA_W signed range.
    function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [WIDE_W-1:0] v);
        logic [DATA_W:0] top;
        top = v[WIDE_W-1:DATA_W-1];
        if (&top || ~|top) begin
            sat_wide = v[DATA_W-1:0];
        end else if (v[WIDE_W-1]) begin
            sat_wide = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_wide = {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [WIDE_W-1:0] s;
        s = WIDE_W'(a) + WIDE_W'(b);
        sat_add = sat_wide(s);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [WIDE_W-1:0] s;
        s = WIDE_W'(a) - WIDE_W'(b);
        sat_sub = sat_wide(s);
    endfunction

    state_t state_q, state_d;
    logic   done_q, done_d;

    logic signed [DATA_W-1:0] x_q, y_q, z_q;
    logic signed [DATA_W-1:0] p0_q, p1_q, p2_q, p3_q;
    logic        [STEP_W-1:0] cnt_q;

    logic signed [DATA_W-1:0] mul_a, mul_b, mul_res;
    logic signed [WIDE_W-1:0] mul_full, mul_shr;
    logic signed [DATA_W-1:0] dy, dz, x_new, y_new, z_new;

    // Shared multiplier: operand selection by state, floor shift, then clamp.
    always_comb begin
        mul_a = x_q;
        mul_b = y_q;
        unique case (state_q)
            StM0: begin
                mul_a = x_q;
                mul_b = sat_sub($signed(RHO), z_q);
            end
            StM2: begin
                mul_a = $signed(SIGMA);
                mul_b = sat_sub(y_q, x_q);
            end
            StM3: begin
                mul_a = $signed(BETA);
                mul_b = z_q;
            end
            default: begin
                mul_a = x_q;
                mul_b = y_q;
            end
        endcase
    end

    assign mul_full = WIDE_W'(mul_a) * WIDE_W'(mul_b);
    assign mul_shr  = mul_full >>> FRAC_W;
    assign mul_res  = sat_wide(mul_shr);

    // Euler update; every term uses the pre-step state.
    assign dy    = sat_sub(p0_q, y_q);
    assign dz    = sat_sub(p1_q, p3_q);
    assign x_new = sat_add(x_q, p2_q >>> DT_SHIFT);
    assign y_new = sat_add(y_q, dy >>> DT_SHIFT);
    assign z_new = sat_add(z_q, dz >>> DT_SHIFT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StM0;
                    end
                end
            end
            StM0:  state_d = StM1;
            StM1:  state_d = StM2;
            StM2:  state_d = StM3;
            StM3:  state_d = StUpd;
            StUpd: state_d = StOut;
            StOut: begin
                if (out_ready) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StM0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            p0_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            p3_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q   <= x0;
                        y_q   <= y0;
                        z_q   <= z0;
                        cnt_q <= num_steps;
                    end
                end
                StM0: p0_q <= mul_res;
                StM1: p1_q <= mul_res;
                StM2: p2_q <= mul_res;
                StM3: p3_q <= mul_res;
                StUpd: begin
                    x_q <= x_new;
                    y_q <= y_new;
                    z_q <= z_new;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_lorenz_euler_core.sv
module tb_lorenz_euler_core;

    localparam int ONE   = 32'h00010000;
    localparam int SIGMA = 32'h000A0000;
    localparam int RHO   = 32'h001C0000;
    localparam int BETA  = 32'h0002AAAB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x0 = '0, y0 = '0, z0 = '0;
    logic [15:0] num_steps = '0;
    logic [31:0] x_out, y_out, z_out;
    logic        out_valid, out_ready = 1'b0, busy, done;

    int errors = 0;
    int checks = 0;

    lorenz_euler_core dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .num_steps (num_steps),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Reference arithmetic on 64-bit integers with explicit range clamping.
    function automatic int sat64(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return int'(v);
    endfunction

    function automatic int smul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat64(p >>> 16);
    endfunction

    function automatic int sadd(input int a, input int b);
        return sat64(longint'(a) + longint'(b));
    endfunction

    function automatic int ssub(input int a, input int b);
        return sat64(longint'(a) - longint'(b));
    endfunction

    task automatic model_step(inout int x, inout int y, inout int z);
        int p0, p1, p2, p3, nx, ny, nz;
        p0 = smul(x, ssub(RHO, z));
        p1 = smul(x, y);
        p2 = smul(SIGMA, ssub(y, x));
        p3 = smul(BETA, z);
        nx = sadd(x, p2 >>> 8);
        ny = sadd(y, ssub(p0, y) >>> 8);
        nz = sadd(z, ssub(p1, p3) >>> 8);
        x = nx;
        y = ny;
        z = nz;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] ix, input logic [31:0] iy,
                            input logic [31:0] iz, input logic [15:0] n);
        x0 = ix;
        y0 = iy;
        z0 = iz;
        num_steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({x_out, y_out, z_out} !== 96'h0) begin
            errors++;
            $display("FAIL reset_state: got x=%h y=%h z=%h, expected all 0", x_out, y_out, z_out);
        end
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got valid/busy/done=%b, expected 000",
                     {out_valid, busy, done});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_step();
        int cyc;
        out_ready = 1'b1;
        do_start(ONE, ONE, ONE, 16'd1);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL single_latency: got out_valid at start+%0d, expected start+6", cyc);
        end
        checks++;
        if ({x_out, y_out, z_out} !== {32'h00010000, 32'h00011A00, 32'h0000FE55}) begin
            errors++;
            $display("FAIL single_values: got %h %h %h, expected 00010000 00011a00 0000fe55",
                     x_out, y_out, z_out);
        end
        tick();
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL single_done: got done/busy/valid=%b, expected 100",
                     {done, busy, out_valid});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        out_ready = 1'b1;
        do_start(32'h7FFF0000, 32'h80000000, 32'h00000000, 16'd1);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (!out_valid || {x_out, y_out, z_out} !== {32'h7F7F0000, 32'h807FFFFF, 32'hFF800000})
        begin
            errors++;
            $display("FAIL saturation: got valid=%b %h %h %h, expected 1 7f7f0000 807fffff ff800000",
                     out_valid, x_out, y_out, z_out);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL saturation_done: got done=%b, expected 1", done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc, transfers, dones, mx, my, mz;
        out_ready = 1'b0;
        mx = ONE;
        my = ONE;
        mz = ONE;
        do_start(ONE, ONE, ONE, 16'd3);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        model_step(mx, my, mz);
        checks++;
        if (!out_valid || {x_out, y_out, z_out} !== {mx, my, mz}) begin
            errors++;
            $display("FAIL bp_first: got valid=%b %h %h %h, expected 1 %h %h %h",
                     out_valid, x_out, y_out, z_out, mx, my, mz);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (!out_valid || {x_out, y_out, z_out} !== {mx, my, mz}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b %h %h %h, expected 1 %h %h %h",
                         i, out_valid, x_out, y_out, z_out, mx, my, mz);
            end
        end
        out_ready = 1'b1;
        transfers = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                transfers++;
                if (transfers > 1) begin
                    model_step(mx, my, mz);
                    checks++;
                    if ({x_out, y_out, z_out} !== {mx, my, mz}) begin
                        errors++;
                        $display("FAIL bp_step%0d: got %h %h %h, expected %h %h %h",
                                 transfers, x_out, y_out, z_out, mx, my, mz);
                    end
                end
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (transfers !== 3 || dones !== 1) begin
            errors++;
            $display("FAIL bp_counts: got %0d transfers %0d dones, expected 3 and 1",
                     transfers, dones);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int transfers, dones, mx, my, mz;
        out_ready = 1'b1;
        do_start(32'h00030000, 32'hFFFE0000, 32'h00050000, 16'd0);
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done: got done/busy/valid=%b, expected 100",
                     {done, busy, out_valid});
        end
        checks++;
        if ({x_out, y_out, z_out} !== {32'h00030000, 32'hFFFE0000, 32'h00050000}) begin
            errors++;
            $display("FAIL zero_values: got %h %h %h, expected 00030000 fffe0000 00050000",
                     x_out, y_out, z_out);
        end
        tick();
        checks++;
        if ({done, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL zero_after: got done/valid=%b, expected 00", {done, out_valid});
        end
        mx = ONE;
        my = ONE;
        mz = ONE;
        do_start(ONE, ONE, ONE, 16'd2);
        tick();
        do_start(32'h12345678, 32'h0, 32'h0, 16'd5);
        transfers = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                transfers++;
                model_step(mx, my, mz);
                checks++;
                if ({x_out, y_out, z_out} !== {mx, my, mz}) begin
                    errors++;
                    $display("FAIL ignored_start_step%0d: got %h %h %h, expected %h %h %h",
                             transfers, x_out, y_out, z_out, mx, my, mz);
                end
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (transfers !== 2 || dones !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_counts: got %0d transfers %0d dones busy=%b, expected 2 1 0",
                     transfers, dones, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        out_ready = 1'b1;
        do_start(ONE, ONE, ONE, 16'd3);
        // now in M0 of step 1; eight more cycles lands in M2 of step 2
        repeat (8) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({x_out, y_out, z_out} !== 96'h0 || {out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_run: got %h %h %h valid/busy/done=%b, expected zeros",
                     x_out, y_out, z_out, {out_valid, busy, done});
        end
        reset = 1'b0;
        tick();
        do_start(ONE, ONE, ONE, 16'd1);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 6 || {x_out, y_out, z_out} !== {32'h00010000, 32'h00011A00, 32'h0000FE55})
        begin
            errors++;
            $display("FAIL after_reset_run: got latency %0d %h %h %h, expected 6 00010000 00011a00 0000fe55",
                     cyc, x_out, y_out, z_out);
        end
        tick();
        tick();
    endtask

    task automatic test_long_run();
        int cyc, transfers, busy_drops, mx, my, mz;
        out_ready = 1'b1;
        mx = ONE;
        my = ONE;
        mz = ONE;
        do_start(ONE, ONE, ONE, 16'd1000);
        cyc = 0;
        transfers = 0;
        busy_drops = 0;
        while (!done && cyc < 8000) begin
            if (!busy) busy_drops++;
            if (out_valid) begin
                transfers++;
                model_step(mx, my, mz);
                checks++;
                if ({x_out, y_out, z_out} !== {mx, my, mz}) begin
                    errors++;
                    $display("FAIL long_step%0d: got %h %h %h, expected %h %h %h",
                             transfers, x_out, y_out, z_out, mx, my, mz);
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL long_timeout: done not seen within %0d cycles", cyc);
        end
        checks++;
        if (transfers !== 1000 || busy_drops !== 0) begin
            errors++;
            $display("FAIL long_counts: got %0d transfers %0d busy drops, expected 1000 and 0",
                     transfers, busy_drops);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_saturation();
        test_backpressure();
        test_zero_and_ignored_start();
        test_reset_mid_run();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
